ps2_kbd_tx: RTL and testbench
=============================

Name: ps2_kbd_tx

Overview:
Device-side PS/2 keyboard transmitter. It is the opposite end of the ps2k receiver. It takes scancode bytes from core logic (for example a USB/OSD keyboard bridge or a macro/autotype engine), buffers them in a small FIFO, and serialises each byte onto an open-collector-style PS/2 clock/data pair, which feeds ps2k's { data, clock } input. Host inhibit (clock held low by the receiving side) is honoured, and any interrupted byte is retransmitted.

Parameters:
AW, 4, FIFO address width; FIFO depth is 2**AW bytes.
HALF, 1600, PS/2 clock half-period in system clocks (1600 at 32 MHz gives a 10 kHz bit rate); minimum 2.
GAP, 4, idle half-periods inserted after each stop bit.

Ports:
clock  in  1  system clock (clock32 domain)
reset  in  1  synchronous, active-low reset
strb  in  1  write strobe; pushes d into the FIFO
d  in  8  scancode byte to send
inhibit  in  1  high when the host is holding PS/2 clock low; already synchronised
ps2Ck  out  1  PS/2 clock to the receiver; idle 1
ps2Dq  out  1  PS/2 data to the receiver; idle 1
full  out  1  FIFO full
empty  out  1  FIFO empty
busy  out  1  frame or gap in progress

Behaviour:
- Reset (reset=0 at a clock edge):
  - Outputs: ps2Ck=1, ps2Dq=1, busy=0, empty=1, full=0.
  - FIFO pointers and count are cleared; state goes to IDLE.
  - Reset in mid-frame discards the frame and all queued bytes.
- FIFO:
  - 2**AW entries, with read/write pointers that wrap modulo the depth, plus an AW+1-bit count.
  - strb while full is ignored: the byte is dropped and no state changes.
  - strb on the same cycle as a pop: both occur and count is unchanged.
  - full and empty are registered and derived from the count.
- Frame format, 11 bits, LSB first: start=0, d[0]..d[7], odd parity (~^d), stop=1.
- Bit cell is 2*HALF clocks:
  - First half: ps2Ck=1, and ps2Dq updates to the new bit on the first cycle of that half.
  - Second half: ps2Ck=0. The receiver samples on the falling edge, so data is stable HALF cycles before it.
- States:
  - IDLE:
    - Transition: if !empty && !inhibit, load the shift register from the FIFO head (peek, no pop), set bitcnt=0, set busy=1, go to HI.
    - Outputs: ps2Ck=1, ps2Dq=1.
  - HI: ps2Ck=1, ps2Dq=sr[bitcnt]. Count HALF clocks, then go to LO.
  - LO:
    - ps2Ck=0. Count HALF clocks.
    - If bitcnt==10: pop the FIFO head, set ps2Dq=1, go to GAP.
    - Otherwise bitcnt++ and go to CHK.
  - CHK: zero-cycle decision, folded into the LO exit.
    - If inhibit=1: abort, with ps2Ck=1, ps2Dq=1, no pop, go to GAP. The byte is retransmitted from the start bit.
    - Otherwise go to HI.
  - GAP:
    - ps2Ck=1, ps2Dq=1. Wait GAP*HALF clocks, then set busy=0 and go to IDLE.
    - IDLE restarts only when inhibit=0.
- Latency: the first ps2Dq fall comes 1 clock after strb into an empty, idle block. First ps2Ck fall at +1+HALF. Full frame is 22*HALF clocks, then GAP*HALF idle.
- inhibit is checked only at IDLE start and at bit boundaries 1..10 (never inside a half-period). Inhibit arriving after the last LO (bit 10 done) does not abort; the byte is already popped.
- Half-period counter is ceil(log2(HALF)) bits and reloads on every state change.

Test Plan:
- HALF=4, GAP=2. strb d=8'h1C → ps2Dq sequence sampled at ps2Ck falls is 0,0,0,1,1,1,0,0,0,0(parity),1. Frame is 88 clocks, empty=1 after the pop, busy falls 8 clocks later.
- Loopback into ps2k. Push 8'hE0 then 8'hF0 then 8'h1C back-to-back → ps2k reports the key-release of 8'h1C once (make=0, code=8'h1C). The bytes arrive in order with ≥GAP*HALF clocks between frames.
- Fill with 16 bytes (AW=4) while inhibit=1 → full=1. A 17th strb is dropped. Release inhibit → exactly 16 frames, in order.
- Raise inhibit during bit 4 → ps2Ck and ps2Dq go high at the next bit boundary, the FIFO count is unchanged, and busy stays high through GAP. Drop inhibit → the same byte is resent from the start bit.
- strb on the exact cycle of the pop with count=1 → count stays 1 and the new byte is sent next.
- reset=0 at mid-frame bit 6 → next cycle ps2Ck=1, ps2Dq=1, empty=1, busy=0, and no further edges occur.

Source files
------------

// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 keyboard transmitter: FIFO-buffered scancodes serialised as
// 11-bit odd-parity frames, with host-inhibit abort and retransmission.
module ps2_kbd_tx #(
  parameter int AW   = 4,
  parameter int HALF = 1600,
  parameter int GAP  = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       strb,
  input  logic [7:0] d,
  input  logic       inhibit,
  output logic       ps2Ck,
  output logic       ps2Dq,
  output logic       full,
  output logic       empty,
  output logic       busy
);
  localparam int DEPTH = 1 << AW;
  localparam int HW    = $clog2(HALF);
  localparam int GW    = $clog2(GAP + 1);

  localparam logic [HW-1:0] HC_END   = HW'(HALF - 1);
  localparam logic [GW-1:0] GC_END   = GW'(GAP - 1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [3:0]    LAST_BIT = 4'd10;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HI   = 2'd1;
  localparam logic [1:0] S_LO   = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt, cnt_nx;
  logic          push, pop;

  logic [1:0]    state;
  logic [HW-1:0] hc;
  logic [GW-1:0] gc;
  logic [3:0]    bitcnt;
  logic [10:0]   sr;
  logic          hc_end;

  assign hc_end = (hc == HC_END);
  assign push   = strb && !full;
  // Head is only popped once the stop bit has completed; aborts leave it queued.
  assign pop    = (state == S_LO) && hc_end && (bitcnt == LAST_BIT);
  assign cnt_nx = cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  always_ff @(posedge clock) begin
    if (push) mem[wp] <= d;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wp     <= '0;
      rp     <= '0;
      cnt    <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      state  <= S_IDLE;
      hc     <= '0;
      gc     <= '0;
      bitcnt <= '0;
      sr     <= '1;
      ps2Ck  <= 1'b1;
      ps2Dq  <= 1'b1;
      busy   <= 1'b0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      cnt   <= cnt_nx;
      full  <= (cnt_nx == CNT_FULL);
      empty <= (cnt_nx == '0);

      // Every state change happens on hc_end, so this also reloads on transitions.
      hc <= (hc_end || state == S_IDLE) ? '0 : hc + HW'(1);

      case (state)
        S_IDLE: begin
          if (!empty && !inhibit) begin
            sr     <= {1'b1, ~^mem[rp], mem[rp], 1'b0};
            bitcnt <= '0;
            busy   <= 1'b1;
            ps2Dq  <= 1'b0;
            state  <= S_HI;
          end
        end
        S_HI: begin
          if (hc_end) begin
            ps2Ck <= 1'b0;
            state <= S_LO;
          end
        end
        S_LO: begin
          if (hc_end) begin
            ps2Ck <= 1'b1;
            if (bitcnt == LAST_BIT || inhibit) begin
              ps2Dq <= 1'b1;
              state <= S_GAP;
            end else begin
              bitcnt <= bitcnt + 4'd1;
              ps2Dq  <= sr[bitcnt + 4'd1];
              state  <= S_HI;
            end
          end
        end
        default: begin
          if (hc_end) begin
            if (gc == GC_END) begin
              gc    <= '0;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              gc <= gc + GW'(1);
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Directed bench for ps2_kbd_tx: a frame decoder on the PS/2 pins feeds a
// scoreboard of bytes queued at strobe time.
module tb_ps2_kbd_tx;
  localparam int AW   = 4;
  localparam int HALF = 4;
  localparam int GAP  = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       strb = 1'b0;
  logic       inhibit = 1'b0;
  logic [7:0] d = 8'h00;
  logic       ps2Ck, ps2Dq, full, empty, busy;

  ps2_kbd_tx #(.AW(AW), .HALF(HALF), .GAP(GAP)) dut (
    .clock(clock), .reset(reset), .strb(strb), .d(d), .inhibit(inhibit),
    .ps2Ck(ps2Ck), .ps2Dq(ps2Dq), .full(full), .empty(empty), .busy(busy)
  );

  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  logic [7:0]  exp_q[$];
  logic [10:0] rx_frame[64];
  int          rx_first[64];
  int          rx_last[64];
  int          rx_n  = 0;
  int          rd    = 0;
  int          nfall = 0;
  int          cyc   = 0;

  // Receiver model: sample data on clock falls; a long clock-high stretch
  // mid-frame means the sender aborted, so the partial frame is dropped.
  initial begin : mon
    logic        prev_ck;
    logic [10:0] sh;
    int          nb;
    int          hicnt;
    prev_ck = 1'b1;
    sh      = '0;
    nb      = 0;
    hicnt   = 0;
    forever begin
      @(negedge clock);
      cyc++;
      if (prev_ck === 1'b1 && ps2Ck === 1'b0) begin
        nfall++;
        if (nb == 0 && rx_n < 64) rx_first[rx_n] = cyc;
        sh[nb] = ps2Dq;
        nb++;
        if (nb == 11) begin
          if (rx_n < 64) begin
            rx_frame[rx_n] = sh;
            rx_last[rx_n]  = cyc;
          end
          rx_n++;
          nb = 0;
        end
      end
      if (ps2Ck === 1'b1) begin
        hicnt++;
        if (hicnt > HALF + 1) nb = 0;
      end else begin
        hicnt = 0;
      end
      prev_ck = ps2Ck;
    end
  end

  function automatic logic [10:0] frame_of(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [7:0] b, input bit expect_it);
    @(negedge clock);
    strb = 1'b1;
    d    = b;
    if (expect_it) exp_q.push_back(b);
    @(negedge clock);
    strb = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    int want;
    n = 0;
    while (((rx_n - rd) < exp_q.size() || !empty || busy) && n < 8000) begin
      @(negedge clock);
      n++;
    end
    want = exp_q.size();
    chk({tag, "_frame_count"}, rx_n - rd, want);
    while (exp_q.size() > 0) begin
      logic [7:0] b;
      b = exp_q.pop_front();
      if (rd < rx_n && rd < 64) begin
        chk({tag, "_frame"}, {21'd0, rx_frame[rd]}, {21'd0, frame_of(b)});
        rd++;
      end
    end
    rd = rx_n;
  endtask

  initial begin : main
    int n;
    int r0;
    int f0;
    logic [7:0] burst[3];
    burst[0] = 8'hE0;
    burst[1] = 8'hF0;
    burst[2] = 8'h1C;

    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_ck", ps2Ck, 1);
    chk("rst_dq", ps2Dq, 1);
    chk("rst_busy", busy, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    reset = 1'b1;

    // Single byte: start-bit latency, frame length, gap length.
    push(8'h1C, 1);
    chk("t1_dq_pre", ps2Dq, 1);
    chk("t1_empty", empty, 0);
    @(negedge clock);
    chk("t1_dq_start", ps2Dq, 0);
    chk("t1_busy", busy, 1);
    n = 0;
    while (!empty && n < 200) begin @(negedge clock); n++; end
    chk("t1_frame_len", n, 22 * HALF);
    n = 0;
    while (busy && n < 100) begin @(negedge clock); n++; end
    chk("t1_gap_len", n, GAP * HALF);
    drain("t1");

    // Break-code sequence pushed on consecutive cycles.
    r0 = rd;
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      strb = 1'b1;
      d    = burst[i];
      exp_q.push_back(burst[i]);
      @(negedge clock);
    end
    strb = 1'b0;
    drain("t2");
    chk("t2_gap01", (rx_first[r0 + 1] - rx_last[r0]) >= GAP * HALF, 1);
    chk("t2_gap12", (rx_first[r0 + 2] - rx_last[r0 + 1]) >= GAP * HALF, 1);

    // Fill under inhibit, overflow strobe dropped.
    inhibit = 1'b1;
    for (int i = 0; i < 16; i++) push(8'h20 + 8'(i * 7), 1);
    chk("t3_full", full, 1);
    push(8'hFF, 0);
    chk("t3_full_after_drop", full, 1);
    chk("t3_idle_busy", busy, 0);
    chk("t3_idle_ck", ps2Ck, 1);
    inhibit = 1'b0;
    drain("t3");
    chk("t3_empty_end", empty, 1);

    // Inhibit during bit 4: abort at the boundary, then resend whole byte.
    push(8'hA5, 1);
    repeat (38) @(negedge clock);
    chk("t5_in_lo", ps2Ck, 0);
    inhibit = 1'b1;
    n = 0;
    while (!ps2Ck && n < 20) begin @(negedge clock); n++; end
    chk("t5_abort_ck", ps2Ck, 1);
    chk("t5_abort_dq", ps2Dq, 1);
    chk("t5_abort_busy", busy, 1);
    chk("t5_abort_empty", empty, 0);
    repeat (20) @(negedge clock);
    chk("t5_hold_busy", busy, 0);
    chk("t5_hold_ck", ps2Ck, 1);
    chk("t5_hold_empty", empty, 0);
    inhibit = 1'b0;
    drain("t5");

    // Strobe on the very cycle the head is popped with one byte queued.
    push(8'h3A, 1);
    repeat (88) @(negedge clock);
    chk("t6_pre_ck", ps2Ck, 0);
    chk("t6_pre_empty", empty, 0);
    strb = 1'b1;
    d    = 8'h55;
    exp_q.push_back(8'h55);
    @(negedge clock);
    strb = 1'b0;
    chk("t6_post_empty", empty, 0);
    chk("t6_post_dq", ps2Dq, 1);
    drain("t6");

    // Reset in mid-frame (bit 6) discards frame and queue.
    push(8'hB1, 0);
    push(8'hB2, 0);
    repeat (48) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("t7_ck", ps2Ck, 1);
    chk("t7_dq", ps2Dq, 1);
    chk("t7_empty", empty, 1);
    chk("t7_busy", busy, 0);
    chk("t7_full", full, 0);
    reset = 1'b1;
    f0 = nfall;
    repeat (200) @(negedge clock);
    chk("t7_no_edges", nfall - f0, 0);
    chk("t7_no_frames", rx_n - rd, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
